seq_mul32: RTL and testbench

//  Unsigned 32x32->64 shift-and-add multiplier, one partial product per cycle.

---
 rtl/seq_mul32_pkg.sv | 26 ++
 rtl/seq_mul32_ksa32.sv | 58 +++++
 rtl/seq_mul32.sv | 144 ++++++++++++++
 tb/tb_seq_mul32.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mul32_pkg.sv
// seq_mul32_pkg
//   Shared definitions for the sequential 32x32->64 multiplier:
//   FSM state encoding, operand/product/counter widths, and a small
//   helper that detects a zero operand pair for the bypass path.
package seq_mul32_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;
    localparam int CNT_W  = 5;

    // The counter value seen on the last of the 32 iteration cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // True when either operand is zero, so the product is trivially zero.
    function automatic logic any_zero(input logic [OP_W-1:0] x,
                                      input logic [OP_W-1:0] y);
        return (x == '0) || (y == '0);
    endfunction

endpackage

// File: rtl/seq_mul32_ksa32.sv
// seq_mul32_ksa32
//   32-bit Kogge-Stone adder used as the per-cycle partial-sum adder of
//   the sequential multiplier. Purely combinational.
// Ports
//   a, b  : 32-bit addends
//   cin   : carry in
//   y     : 32-bit sum
//   cout  : carry out of bit 31
module seq_mul32_ksa32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] y,
    output logic        cout
);

    logic [31:0] prop0;
    logic [31:0] grp_g;
    logic [31:0] grp_p;
    logic [31:0] gv;
    logic [31:0] pv;
    logic [31:0] gn;
    logic [31:0] pn;
    logic [32:0] carry;

    assign prop0 = a ^ b;

    // Five prefix stages with spans 1,2,4,8,16. After the last stage each
    // bit i holds the group generate/propagate of bits i..0.
    always_comb begin
        gv = a & b;
        pv = a ^ b;
        gn = '0;
        pn = '0;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 32; i++) begin
                if (i >= (1 << k)) begin
                    gn[i] = gv[i] | (pv[i] & gv[i - (1 << k)]);
                    pn[i] = pv[i] & pv[i - (1 << k)];
                end else begin
                    gn[i] = gv[i];
                    pn[i] = pv[i];
                end
            end
            gv = gn;
            pv = pn;
        end
        grp_g = gv;
        grp_p = pv;
    end

    // Carry into bit i+1 is the group generate of bits i..0, or the group
    // propagate letting cin through.
    assign carry = {grp_g | (grp_p & {32{cin}}), cin};
    assign y     = prop0 ^ carry[31:0];
    assign cout  = carry[32];

endmodule

// File: rtl/seq_mul32.sv
// seq_mul32
//   Unsigned 32x32->64 shift-and-add multiplier retiring one partial
//   product per cycle through a 32-bit Kogge-Stone adder. Operands arrive
//   on a valid/ready port, the product leaves on a valid/ready port.
// Parameters
//   WIDTH       : operand width, 32 only (the adder is fixed 32-bit)
//   BYPASS_ZERO : 1 = a zero operand skips iteration and yields 0 at once
// Ports
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   in_valid    : operand pair valid
//   in_ready    : block accepts operands (IDLE only)
//   a, b        : multiplicand, multiplier
//   out_valid   : p holds a finished product
//   out_ready   : consumer accepts p
//   p           : 64-bit product
//   busy        : high while computing or holding a result
module seq_mul32
    import seq_mul32_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter bit BYPASS_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] p,
    output logic              busy
);

    state_t state;
    state_t next_state;

    logic [WIDTH-1:0]  mcand;
    logic [WIDTH-1:0]  acc_hi;
    logic [WIDTH-1:0]  acc_lo;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  add_b;
    logic [WIDTH-1:0]  sum_y;
    logic              sum_cout;
    logic              take_bypass;
    logic [PROD_W-1:0] next_acc;

    assign take_bypass = BYPASS_ZERO && any_zero(a, b);

    // The multiplicand is added only when the multiplier bit currently at
    // the bottom of the shift register is set.
    assign add_b = acc_lo[0] ? mcand : '0;

    seq_mul32_ksa32 u_ksa (
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0),
        .y    (sum_y),
        .cout (sum_cout)
    );

    // The carry is kept as the top bit, so the 33-bit partial sum and the
    // remaining 31 multiplier bits shift right together as one 64-bit word.
    assign next_acc = {sum_cout, sum_y, acc_lo[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake outputs depend on state alone, so in_ready never loops
    // back through in_valid.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = take_bypass ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: operands load on accept, the accumulator shifts once per
    // CALC cycle, and p captures the final word (or zero on bypass). p is
    // otherwise untouched so it stays stable while the result waits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            p      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= a;
                        acc_lo <= b;
                        acc_hi <= '0;
                        cnt    <= '0;
                        if (take_bypass) begin
                            p <= '0;
                        end
                    end
                end
                CALC: begin
                    acc_hi <= next_acc[PROD_W-1:WIDTH];
                    acc_lo <= next_acc[WIDTH-1:0];
                    cnt    <= cnt + 5'd1;
                    if (cnt == CNT_LAST) begin
                        p <= next_acc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul32.sv
// tb_seq_mul32
//   Self-checking bench for seq_mul32. Expected products are computed
//   here with a 64-bit multiply, queued when operands are accepted and
//   compared when the DUT hands a result over.
module tb_seq_mul32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] p;
    logic        busy;

    logic        nb_in_valid = 1'b0;
    logic        nb_in_ready;
    logic [31:0] nb_a = '0;
    logic [31:0] nb_b = '0;
    logic        nb_out_valid;
    logic        nb_out_ready = 1'b0;
    logic [63:0] nb_p;
    logic        nb_busy;

    logic [63:0] expQ[$];
    int          checkCount = 0;
    int          passCount = 0;

    always #5 clk = ~clk;

    seq_mul32 #(.WIDTH(32), .BYPASS_ZERO(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    seq_mul32 #(.WIDTH(32), .BYPASS_ZERO(1'b0)) dut_nb (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (nb_in_valid),
        .in_ready  (nb_in_ready),
        .a         (nb_a),
        .b         (nb_b),
        .out_valid (nb_out_valid),
        .out_ready (nb_out_ready),
        .p         (nb_p),
        .busy      (nb_busy)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] refProduct(input logic [31:0] x, input logic [31:0] y);
        return {32'd0, x} * {32'd0, y};
    endfunction

    function automatic logic [31:0] randOperand();
        case ($urandom_range(15))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Offers one operand pair, queues its product once accepted, then
    // counts cycles (accept cycle = 0) until out_valid, checking busy.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                 input string tag, output int lat);
        int guard;
        int busyLow;
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput({tag, "_accept"}, 64'(in_ready), 64'd1);
        expQ.push_back(refProduct(av, bv));
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        busyLow = 0;
        while (!out_valid && lat < 100) begin
            if (!busy || in_ready) busyLow++;
            @(negedge clk);
            lat++;
        end
        if (!busy || in_ready) busyLow++;
        checkOutput({tag, "_busy"}, 64'(busyLow), 64'd0);
    endtask

    // Takes the waiting result and compares it with the queued product.
    task automatic retireResult(input string tag);
        checkOutput({tag, "_sb_depth"}, 64'(expQ.size()), 64'd1);
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        if (expQ.size() > 0) checkOutput({tag, "_p"}, p, expQ.pop_front());
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput({tag, "_cleared"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int stale;
        int holdErr;
        int accepted;
        int retired;
        int cycles;
        logic stall;
        logic [63:0] heldP;

        // Reset state
        #12;
        checkOutput("rst_p", p, 64'd0);
        checkOutput("rst_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a computation discards it
        @(negedge clk);
        a = 32'd3;
        b = 32'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("mid_busy", 64'(busy), 64'd1);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_ready", 64'(in_ready), 64'd1);
        checkOutput("mid_rst_p", p, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        out_ready = 1'b0;
        checkOutput("mid_rst_stale", 64'(stale), 64'd0);

        // Basic product and latency
        applyStimulus(32'd3, 32'd5, "basic", lat);
        checkOutput("basic_lat", 64'(lat), 64'd33);
        checkOutput("basic_const", p, 64'd15);
        retireResult("basic");

        // Largest operands: carry feeds acc_hi every cycle
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max", lat);
        checkOutput("max_lat", 64'(lat), 64'd33);
        checkOutput("max_const", p, 64'hFFFF_FFFE_0000_0001);
        retireResult("max");

        // Zero operand takes the bypass path
        applyStimulus(32'd0, 32'h1234, "bypass", lat);
        checkOutput("bypass_lat", 64'(lat), 64'd1);
        checkOutput("bypass_const", p, 64'd0);
        retireResult("bypass");

        // Same zero operand with bypass disabled iterates fully
        checkOutput("nb_ready", 64'(nb_in_ready), 64'd1);
        @(negedge clk);
        nb_a = 32'd0;
        nb_b = 32'h1234;
        nb_in_valid = 1'b1;
        @(negedge clk);
        nb_in_valid = 1'b0;
        lat = 1;
        while (!nb_out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("nobypass_lat", 64'(lat), 64'd33);
        checkOutput("nobypass_p", nb_p, 64'd0);
        nb_out_ready = 1'b1;
        @(negedge clk);
        nb_out_ready = 1'b0;
        checkOutput("nobypass_cleared", 64'(nb_out_valid), 64'd0);

        // Backpressure: result and flags must hold while out_ready is low
        applyStimulus(32'h8000_0000, 32'd2, "bp", lat);
        checkOutput("bp_lat", 64'(lat), 64'd33);
        in_valid = 1'b1;
        holdErr = 0;
        repeat (5) begin
            if (!out_valid || in_ready || p !== 64'h1_0000_0000) holdErr++;
            @(negedge clk);
        end
        checkOutput("bp_hold", 64'(holdErr), 64'd0);
        checkOutput("bp_const", p, 64'h1_0000_0000);
        retireResult("bp");
        // in_valid was high through DONE; the first accept happens in IDLE now
        checkOutput("bp_no_early_accept", 64'(busy), 64'd0);
        in_valid = 1'b0;

        // Random traffic with random gaps on both ports
        accepted = 0;
        retired = 0;
        cycles = 0;
        stall = 1'b0;
        heldP = '0;
        while ((accepted < 1000 || expQ.size() > 0) && cycles < 60000) begin
            @(negedge clk);
            cycles++;
            if (stall) begin
                checkOutput("rand_hold_valid", 64'(out_valid), 64'd1);
                checkOutput("rand_hold_p", p, heldP);
            end
            in_valid = (accepted < 1000) && ($urandom_range(3) != 0);
            a = randOperand();
            b = randOperand();
            out_ready = ($urandom_range(3) != 0);
            if (in_valid && in_ready) begin
                expQ.push_back(refProduct(a, b));
                accepted++;
            end
            if (out_valid && out_ready) begin
                if (expQ.size() > 0) checkOutput("rand_p", p, expQ.pop_front());
                else checkOutput("rand_sb_depth", 64'(expQ.size()), 64'd1);
                retired++;
            end
            stall = out_valid && !out_ready;
            heldP = p;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("rand_accepted", 64'(accepted), 64'd1000);
        checkOutput("rand_retired", 64'(retired), 64'd1000);
        checkOutput("rand_sb_empty", 64'(expQ.size()), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
